// File: rtl/clock_phase_detector.sv
// Receive-side phase/period meter for an externally phased periodic signal.
// Measures rise-to-rise period and offset from ref_tick, and flags lock once both are stable.
module clock_phase_detector #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_tick,
  input  logic             phased_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             lost
);
  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W+1)'(TOL);
  localparam logic [MC_W-1:0]  LOCK_LAST = MC_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {UNLOCKED, TRACKING, LOCKED} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_last_q, sync_last_d;
  logic [CNT_W-1:0]       ph_cnt_q, ph_cnt_d;
  logic [CNT_W-1:0]       per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       phase_q, phase_d;
  logic                   phase_valid_q, phase_valid_d;
  logic                   locked_q, locked_d;
  logic                   lost_q, lost_d;
  logic                   prev_valid_q, prev_valid_d;
  logic                   sat_q, sat_d;
  logic [MC_W-1:0]        match_cnt_q, match_cnt_d;
  state_t                 state_q, state_d;

  logic             rise, sat_hit, match;
  logic [CNT_W-1:0] new_phase;
  logic [CNT_W:0]   per_diff, ph_diff;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], phased_in};
    sync_last_d = sync_q[SYNC_STAGES-1];
    rise        = sync_q[SYNC_STAGES-1] & ~sync_last_q;
    // A rise in the saturating cycle is a valid (maximal) measurement, not a loss.
    sat_hit     = (per_cnt_q == CNT_MAX) & ~sat_q & ~rise;
    new_phase   = ref_tick ? '0 : ph_cnt_q;

    per_diff = (per_cnt_q >= period_q) ? ({1'b0, per_cnt_q} - {1'b0, period_q})
                                       : ({1'b0, period_q} - {1'b0, per_cnt_q});
    ph_diff  = (new_phase >= phase_q)  ? ({1'b0, new_phase} - {1'b0, phase_q})
                                       : ({1'b0, phase_q} - {1'b0, new_phase});
    match    = prev_valid_q & (per_diff <= TOL_V) & (ph_diff <= TOL_V);

    ph_cnt_d  = ref_tick ? CNT_W'(1)
              : (ph_cnt_q == CNT_MAX) ? ph_cnt_q : ph_cnt_q + CNT_W'(1);
    per_cnt_d = rise ? CNT_W'(1)
              : (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_W'(1);
    sat_d     = rise ? 1'b0 : (sat_q | sat_hit);

    state_d       = state_q;
    match_cnt_d   = match_cnt_q;
    prev_valid_d  = prev_valid_q;
    period_d      = period_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    lost_d        = 1'b0;

    if (rise) begin
      phase_valid_d = 1'b1;
      phase_d       = new_phase;
      prev_valid_d  = 1'b1;
      // The first rise has no earlier edge to measure against.
      if (prev_valid_q) period_d = per_cnt_q;
      case (state_q)
        UNLOCKED: begin
          state_d     = TRACKING;
          match_cnt_d = '0;
        end
        TRACKING: begin
          if (match) begin
            match_cnt_d = match_cnt_q + MC_W'(1);
            if (match_cnt_q == LOCK_LAST) state_d = LOCKED;
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_d     = TRACKING;
            match_cnt_d = '0;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end else if (sat_hit) begin
      state_d      = UNLOCKED;
      lost_d       = 1'b1;
      prev_valid_d = 1'b0;
      match_cnt_d  = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      sync_last_q   <= 1'b0;
      ph_cnt_q      <= '0;
      per_cnt_q     <= '0;
      period_q      <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      lost_q        <= 1'b0;
      prev_valid_q  <= 1'b0;
      sat_q         <= 1'b0;
      match_cnt_q   <= '0;
      state_q       <= UNLOCKED;
    end else begin
      sync_q        <= sync_d;
      sync_last_q   <= sync_last_d;
      ph_cnt_q      <= ph_cnt_d;
      per_cnt_q     <= per_cnt_d;
      period_q      <= period_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      locked_q      <= locked_d;
      lost_q        <= lost_d;
      prev_valid_q  <= prev_valid_d;
      sat_q         <= sat_d;
      match_cnt_q   <= match_cnt_d;
      state_q       <= state_d;
    end
  end

  assign period      = period_q;
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign locked      = locked_q;
  assign lost        = lost_q;
endmodule

// File: tb/tb_clock_phase_detector.sv
// Bench for clock_phase_detector: event-time reference model feeds a scoreboard,
// a negedge monitor pops and compares on every phase_valid / lost pulse.
module tb_clock_phase_detector;
  localparam int CNT_W = 8;
  localparam int SS    = 2;
  localparam int LC    = 4;
  localparam int TOL   = 1;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ref_tick = 1'b0;
  logic phased_in = 1'b0;
  logic [CNT_W-1:0] period, phase;
  logic phase_valid, locked, lost;

  clock_phase_detector #(.CNT_W(CNT_W), .SYNC_STAGES(SS), .LOCK_CNT(LC), .TOL(TOL)) dut (
    .clk(clk), .rst(rst), .ref_tick(ref_tick), .phased_in(phased_in),
    .period(period), .phase(phase), .phase_valid(phase_valid),
    .locked(locked), .lost(lost)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int ph; int per; bit lk; } exp_t;
  exp_t exp_q[$];
  int   lost_q[$];
  int   rise_q[$];
  int   ref_q[$];
  exp_t mon_e;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int pv_cnt = 0, lost_cnt = 0, ph0_cnt = 0, lock_at = 0, unlock_at = 0;
  bit exp_lk = 1'b0, lk_prev = 1'b0;

  // stimulus waveform state
  int pos = 0, cur_len = 16, plen = 16, nxt_off = 3, n_rise_drv = 0;
  bit run_on = 1'b0, rand_mode = 1'b0, alt_mode = 1'b0;

  // reference model state, in absolute cycle numbers
  int m_last_ref = 0, m_last_rise = 0, m_per = 0, m_ph = 0, m_streak = 0;
  bit m_prev_valid = 1'b0, m_locked = 1'b0, m_sat = 1'b0;

  function automatic int sat_c(int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_phase_valid"}, phase_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_lost"}, lost, 0);
  endtask

  // One clock cycle: drive inputs for cycle cyc, then advance the model.
  task automatic step();
    bit   rtk, rs, match;
    int   ph, per;
    exp_t e;
    @(posedge clk); #1; cyc++;
    if (rst) begin
      ref_tick = 1'b0; phased_in = 1'b0;
      return;
    end
    rtk = 1'b0;
    while (ref_q.size() > 0 && ref_q[0] < cyc) void'(ref_q.pop_front());
    if (ref_q.size() > 0 && ref_q[0] == cyc) begin
      rtk = 1'b1; void'(ref_q.pop_front());
    end
    if (run_on) begin
      if (pos == cur_len) pos = 0;
      if (pos == 0) begin
        if (rand_mode) begin
          if ($urandom_range(0, 3) == 0) begin
            cur_len = 12 + $urandom_range(0, 8);
            nxt_off = $urandom_range(0, 10);
          end else begin
            cur_len = 15 + $urandom_range(0, 2);
            nxt_off = 2 + $urandom_range(0, 2);
          end
        end else begin
          cur_len = plen;
          if (alt_mode) nxt_off = (nxt_off == 3) ? 4 : 3;
        end
        ref_q.push_back(cyc + cur_len - nxt_off);
        rise_q.push_back(cyc + SS);
        n_rise_drv++;
      end
      phased_in = (pos >= 0) && (pos < cur_len / 2);
      pos++;
    end else begin
      phased_in = 1'b0;
    end
    ref_tick = rtk;

    if (rtk) m_last_ref = cyc;
    rs = (rise_q.size() > 0 && rise_q[0] == cyc);
    if (rs) begin
      void'(rise_q.pop_front());
      ph = rtk ? 0 : sat_c(cyc - m_last_ref);
      if (!m_prev_valid) begin
        m_prev_valid = 1'b1; m_locked = 1'b0; m_streak = 0;
      end else begin
        per   = sat_c(cyc - m_last_rise);
        match = (iabs(per - m_per) <= TOL) && (iabs(ph - m_ph) <= TOL);
        m_per = per;
        if (!match) begin
          m_locked = 1'b0; m_streak = 0;
        end else if (!m_locked) begin
          m_streak++;
          if (m_streak == LC) m_locked = 1'b1;
        end
      end
      m_ph = ph; m_last_rise = cyc; m_sat = 1'b0;
      e.cyc = cyc + 1; e.ph = ph; e.per = m_per; e.lk = m_locked;
      exp_q.push_back(e);
    end else if (!m_sat && (cyc - m_last_rise) >= MAXC) begin
      lost_q.push_back(cyc + 1);
      m_sat = 1'b1; m_prev_valid = 1'b0; m_locked = 1'b0; m_streak = 0;
    end
  endtask

  task automatic rel_reset();
    @(posedge clk); #1; cyc++;
    ref_tick = 1'b0; phased_in = 1'b0; rst = 1'b0; run_on = 1'b0;
    exp_q.delete(); lost_q.delete(); rise_q.delete(); ref_q.delete();
    m_last_ref = cyc; m_last_rise = cyc; m_per = 0; m_ph = 0; m_streak = 0;
    m_prev_valid = 1'b0; m_locked = 1'b0; m_sat = 1'b0;
  endtask

  task automatic start_run();
    ref_q.delete();
    ref_q.push_back(cyc + 1);
    pos = -nxt_off; cur_len = plen; run_on = 1'b1;
  endtask

  task automatic stop_run();
    int guard = 0;
    while (run_on && pos >= 0 && pos <= cur_len / 2 && guard < 64) begin
      step(); guard++;
    end
    run_on = 1'b0;
    ref_q.delete();
  endtask

  task automatic run_rises(int n);
    int tgt = n_rise_drv + n;
    int guard = 0;
    while (n_rise_drv < tgt && guard < 2000) begin
      step(); guard++;
    end
    if (n_rise_drv < tgt) begin
      n_chk++; n_fail++;
      $display("FAIL run_rises: stimulus stalled at %0d of %0d rises", n_rise_drv, tgt);
    end
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compares every DUT measurement against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_lk  = 1'b0;
      lk_prev = 1'b0;
    end else begin
      if (phase_valid) begin
        pv_cnt++;
        if (phase == '0) ph0_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL pv_unexpected: phase_valid with nothing pending, phase %0d period %0d (cycle %0d)",
                   phase, period, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pv_cycle", cyc, mon_e.cyc);
          chk("phase", phase, mon_e.ph);
          chk("period", period, mon_e.per);
          chk("locked_at_pv", locked, mon_e.lk);
          exp_lk = mon_e.lk;
        end
        if (locked && !lk_prev) lock_at = pv_cnt;
        if (!locked && lk_prev) unlock_at = pv_cnt;
      end
      if (lost) begin
        lost_cnt++;
        if (lost_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL lost_unexpected: lost pulse with none pending (cycle %0d)", cyc);
        end else begin
          chk("lost_cycle", cyc, lost_q.pop_front());
        end
        exp_lk = 1'b0;
      end
      chk("locked_track", locked, exp_lk);
      lk_prev = locked;
    end
  end

  initial begin
    int base, ul0, lc0, z0;

    // reset values
    steps(3);
    chk_zero_outputs("rst_hold");
    rel_reset();
    step();
    chk_zero_outputs("rst_release");

    // steady lock: period 16, rise 3 cycles after ref_tick
    plen = 16; nxt_off = 3; base = pv_cnt;
    start_run();
    run_rises(8);
    steps(4);
    chk("steady_lock_pv", lock_at - base, 6);
    chk("steady_locked", locked, 1);

    // tolerance: offset alternates 3/4, then jumps to 7
    ul0 = unlock_at;
    alt_mode = 1'b1;
    run_rises(8);
    chk("alt_no_unlock", unlock_at, ul0);
    chk("alt_locked", locked, 1);
    alt_mode = 1'b0; nxt_off = 7;
    run_rises(8);
    steps(4);
    chk("jump_unlocked_once", (unlock_at != ul0), 1);
    chk("jump_relock_gap", lock_at - unlock_at, 4);

    // loss of signal
    lc0 = lost_cnt;
    stop_run();
    steps(300);
    chk("loss_lost_pulses", lost_cnt - lc0, 1);
    chk("loss_locked", locked, 0);
    nxt_off = 3;
    start_run();
    run_rises(8);

    // coincidence of ref_tick and rise
    z0 = ph0_cnt;
    nxt_off = -2;
    run_rises(1);
    nxt_off = 3;
    run_rises(8);
    steps(4);
    chk("coincide_phase0", ph0_cnt - z0, 1);
    chk("coincide_relocked", locked, 1);

    // asynchronous reset while locked
    stop_run();
    steps(6);
    chk("pre_rst_locked", locked, 1);
    chk("pre_rst_drain", exp_q.size(), 0);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("async_rst");
    steps(2);
    rel_reset();
    nxt_off = 3; base = pv_cnt;
    start_run();
    run_rises(8);
    steps(4);
    chk("rst_relock_pv", lock_at - base, 6);

    // randomized period / offset jitter
    rand_mode = 1'b1;
    run_rises(40);
    rand_mode = 1'b0;
    stop_run();
    steps(10);
    chk("final_exp_drain", exp_q.size(), 0);
    chk("final_lost_drain", lost_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_phase_detector.md
# clock_phase_detector

Receive-side companion to the clock phasing block. It samples an externally phased, periodic clock-like signal in the local `clk` domain, measures its period and its phase offset relative to a local reference tick, and asserts `locked` once both measurements are stable. It sits at the destination of a phased clock. It gives downstream logic a qualified phase/period measurement, so that logic never uses the raw delayed edge.

## Interface
- `CNT_W`, 8: width of the period and phase counters and outputs.
- `SYNC_STAGES`, 2: synchronizer depth on `phased_in`; legal values ≥ 2.
- `LOCK_CNT`, 4: number of consecutive matching measurements required to lock; legal values ≥ 1.
- `TOL`, 1: allowed absolute difference, in cycles, between consecutive measurements that still counts as a match.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ref_tick`  in  1  single-cycle pulse marking local phase zero; synchronous to `clk`.
- `phased_in`  in  1  phased periodic signal; asynchronous to `clk`.
- `period`  out  CNT_W  last measured rise-to-rise spacing, in cycles.
- `phase`  out  CNT_W  last measured offset from `ref_tick` to the synchronized rise.
- `phase_valid`  out  1  one-cycle pulse when `phase` (and, from the 2nd rise on, `period`) updates.
- `locked`  out  1  measurements are stable.
- `lost`  out  1  one-cycle pulse when the period counter saturates.

## Operation
- **Synchronizer:** `phased_in` passes through a chain of SYNC_STAGES flops, then one more flop `sync_d`. The rise strobe is `rise = sync & ~sync_d`.
- **Phase counter:**
  - On `ref_tick`, it loads 1.
  - Otherwise it increments and saturates at 2^CNT_W-1.
  - Captured value = 0 if `ref_tick` and `rise` occur in the same cycle; otherwise it is the current count.
- **Period counter:**
  - On `rise`, it loads 1.
  - Otherwise it increments and saturates at 2^CNT_W-1.
  - Captured value on `rise` = current count, i.e. the rise-to-rise spacing P.
- **First rise after reset:** captures `phase` only. `period` is held and `prev_period_valid` is set.
- **Match condition:** |new_period - prev_period| ≤ TOL and |new_phase - prev_phase| ≤ TOL, evaluated only when `prev_period_valid` is set. Differences are unsigned magnitudes computed at CNT_W+1 bits.
- **FSM states:**
  - UNLOCKED (reset state): on `rise`, go to TRACKING with `match_cnt` = 0.
  - TRACKING: on `rise` with a match, `match_cnt` increments; when it reaches LOCK_CNT, go to LOCKED. On `rise` without a match, clear `match_cnt`.
  - LOCKED: on `rise` without a match, go to TRACKING and clear `match_cnt`.
  - Any state: period counter reaching saturation forces UNLOCKED, pulses `lost`, and clears `prev_period_valid` and `match_cnt`. Saturation is re-flagged only after the next `rise`.
- **Output qualification:** `locked` is high only in LOCKED.
- **Reset:** all registers clear immediately, mid-operation included. Reset values: `period`=0, `phase`=0, `phase_valid`=0, `locked`=0, `lost`=0, synchronizer flops 0.

## Timing
- Cycle k is the interval after edge k.
- If `phased_in` goes high during cycle t, `rise` is high in cycle t+SYNC_STAGES. Outputs update at edge t+SYNC_STAGES+1.
- Reported `phase` = true offset from the `ref_tick` cycle + SYNC_STAGES.
- `phase_valid`, `locked` transitions and `lost` are all registered and take effect at the same edge as the corresponding output update.
- Throughput: one measurement per `rise`. Minimum legal `phased_in` high and low widths are SYNC_STAGES+1 cycles each.

## Test plan
- **Reset values:** assert `rst` for 3 cycles → `period`=0, `phase`=0, `phase_valid`=0, `locked`=0, `lost`=0.
- **Steady lock:** `ref_tick` every 16 cycles; `phased_in` period 16, 50% duty, rising 3 cycles after each `ref_tick` → `phase`=5 on every `phase_valid`, `period`=16 from the 2nd rise, `locked` rises with the 6th `phase_valid`.
- **Tolerance:** once locked, alternate the rise offset between 3 and 4 → `locked` stays high, `phase` alternates 5/6. Jump the offset to 7 → `locked` falls at that `phase_valid`, then re-locks after 4 further stable rises.
- **Loss of signal:** once locked, hold `phased_in` low → 255 cycles after the last rise `lost` pulses for one cycle and `locked`=0. On restart, the first rise updates `phase` only.
- **Coincidence:** drive the rise so that `rise` lands in the same cycle as `ref_tick` → captured `phase`=0.
- **Reset mid-lock:** pulse `rst` asynchronously (off-edge) while `locked`=1 → all outputs are 0 before the next `clk` edge, and lock is re-acquired at the 6th rise after reset release.
